// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with one-cycle load-use stall and flush; define IF_ID_STALL_CNT_EN to add a saturating stall counter
module if_id_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        if_flush,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic        pc_write,
  output logic        ctrl_bubble
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  typedef enum logic {RUN, STALL} state_e;
  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        hazard, stall;
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  // A bubble (valid_q=0) can never stall; register 0 never creates a dependency.
  assign hazard = valid_q & id_ex_mem_read & (id_ex_rt != 5'd0) &
                  ((id_ex_rt == instr_q[25:21]) | (id_ex_rt == instr_q[20:16]));
  // Stall only from RUN and only when no flush; this also yields pc_write=1 during reset.
  always_comb begin
    stall       = (state_q == RUN) & hazard & if_flush;
    pc_write    = ~stall;
    ctrl_bubble = stall;
    state_d     = stall ? STALL : RUN;
    instr_d     = !if_flush ? NOP_WORD : stall ? instr_q : instr_in;
    pc_d        = stall ? pc_q : pc_plus4_in;
    valid_d     = if_flush;
  end
  // Pipeline register and FSM state, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      instr_q <= NOP_WORD;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end
  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_q;
  assign valid_out    = valid_q;
`ifdef IF_ID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  // Count stall entries, sticking at all-ones.
  always_comb begin
    stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  // Counter is cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
